// File: rtl/dmem_bus_bridge.sv
// CPU data-memory port to valid/ready bus bridge: byte-lane alignment, stall, timeout.
// Define MISALIGN_CHECK_EN to reject lane-crossing accesses with cpu_err instead of truncating.
module dmem_bus_bridge #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_read,
  input  logic [3:0]        cpu_write,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_err,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_we,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-3:0]   addr_q, addr_d;
  logic [3:0]          we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          off_q, off_d;
  logic                wr_q, wr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                valid_q, valid_d;

  logic                req_s;
  logic [1:0]          off_s;
  logic                misalign_s;
  logic                timeout_s;
  logic [CNT_W-1:0]    cnt_inc_s;

  assign req_s     = cpu_read | (|cpu_write);
  assign off_s     = cpu_addr[1:0];
  assign timeout_s = (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));
  assign cnt_inc_s = (cnt_q == CNT_W'(TIMEOUT_CYC)) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef MISALIGN_CHECK_EN
  // A write crosses lane 3 when any enable sits above bit (3-off); loads count as words.
  assign misalign_s = (|cpu_write) ? (|(cpu_write & ~(4'hF >> off_s)))
                                   : (cpu_read & (off_s != 2'd0));
`else
  assign misalign_s = 1'b0;
`endif

  // Stall is gated by reset so a held request cannot stall the CPU while the bridge is in reset.
  assign cpu_stall = rst & (((state_q == S_IDLE) & req_s) |
                            (state_q == S_REQ) | (state_q == S_WAIT_R));

  assign cpu_rdata = rdata_q;
  assign cpu_err   = err_q;
  assign bus_valid = valid_q;
  assign bus_addr  = {addr_q, 2'b00};
  assign bus_we    = we_q;
  assign bus_wdata = wdata_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          addr_d = cpu_addr[ADDR_W-1:2];
          off_d  = off_s;
          wr_d   = |cpu_write;
          if (misalign_s) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
            valid_d = 1'b0;
          end else begin
            state_d = S_REQ;
            valid_d = 1'b1;
            cnt_d   = '0;
            // Write wins over a simultaneous read; a pure read drives zero enables.
            if (|cpu_write) begin
              we_d    = cpu_write << off_s;
              wdata_d = cpu_wdata << {off_s, 3'b000};
            end else begin
              we_d    = 4'b0000;
              wdata_d = '0;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_inc_s;
          state_d = wr_q ? S_DONE : S_WAIT_R;
        end else if (timeout_s) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      S_WAIT_R: begin
        if (bus_rvalid) begin
          rdata_d = bus_rdata >> {off_q, 3'b000};
          state_d = S_DONE;
        end else if (timeout_s) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset discards any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 4'b0000;
      wdata_q <= '0;
      off_q   <= 2'b00;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed table-driven bench for dmem_bus_bridge plus hand sequences for
// timeout, reset mid-access, late rvalid and lane truncation / misalign rejection.
module tb_dmem_bus_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic        cpu_read = 1'b0;
  logic [3:0]  cpu_write = 4'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, cpu_err, bus_valid;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_addr;
  logic [3:0]  bus_we;
  logic [31:0] bus_wdata;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  logic        to_read = 1'b0;
  logic [31:0] to_cpu_rdata, to_bus_addr, to_bus_wdata;
  logic        to_cpu_stall, to_cpu_err, to_bus_valid;
  logic [3:0]  to_bus_we;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_bus_bridge dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  dmem_bus_bridge #(.TIMEOUT_CYC(4)) dut_to (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_read(to_read), .cpu_write(4'h0), .cpu_wdata(cpu_wdata),
    .cpu_rdata(to_cpu_rdata), .cpu_stall(to_cpu_stall), .cpu_err(to_cpu_err),
    .bus_valid(to_bus_valid), .bus_ready(1'b0), .bus_addr(to_bus_addr),
    .bus_we(to_bus_we), .bus_wdata(to_bus_wdata), .bus_rvalid(1'b0), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic [3:0]  wr;
    logic [31:0] wd;
    logic [31:0] brd;
    int          hold;     // REQ cycles with ready low before ready rises
    bit          give_rv;  // bus returns rvalid the cycle after the handshake
    logic [31:0] e_addr;
    logic [3:0]  e_we;
    logic [31:0] e_wd;
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_stall;
    int          e_valid;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int stall_n = 0;
    int valid_n = 0;
    bit done = 1'b0;
    bit unstable = 1'b0;
    bit rv_pend = 1'b0;
    logic [31:0] s_addr = 32'h0;
    logic [3:0]  s_we = 4'h0;
    logic [31:0] s_wd = 32'h0;
    logic [31:0] rdata_s = 32'h0;
    logic        err_s = 1'b0;
    @(posedge clk); #1;
    cpu_addr = v.addr; cpu_read = v.rd; cpu_write = v.wr; cpu_wdata = v.wd;
    bus_rdata = v.brd; bus_rvalid = 1'b0;
    bus_ready = (v.hold == 0);
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      bus_rvalid = rv_pend;
      rv_pend = 1'b0;
      if (bus_valid) begin
        valid_n++;
        if (valid_n > 1 && {bus_addr, bus_we, bus_wdata} !== {s_addr, s_we, s_wd}) unstable = 1'b1;
        s_addr = bus_addr; s_we = bus_we; s_wd = bus_wdata;
        bus_ready = (valid_n > v.hold);
        if (bus_ready && bus_we == 4'h0 && v.give_rv) rv_pend = 1'b1;
      end
      if (cpu_stall) stall_n++;
      else begin
        done = 1'b1;
        err_s = cpu_err;
        rdata_s = cpu_rdata;
      end
    end
    cpu_read = 1'b0; cpu_write = 4'h0; bus_rvalid = 1'b0;
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_stall_cycles"}, stall_n, v.e_stall);
    chk({nm, "_valid_cycles"}, valid_n, v.e_valid);
    chk({nm, "_stable"}, 32'(unstable), 32'd0);
    if (v.e_valid > 0) begin
      chk({nm, "_bus_addr"}, s_addr, v.e_addr);
      chk({nm, "_bus_we"}, 32'(s_we), 32'(v.e_we));
      chk({nm, "_bus_wdata"}, s_wd, v.e_wd);
    end
    chk({nm, "_err"}, 32'(err_s), 32'(v.e_err));
    chk({nm, "_rdata"}, rdata_s, v.e_rdata);
  endtask

  task automatic reset_mid(input bit in_wait, input string nm);
    bit seen = 1'b0;
    bit hit = 1'b0;
    @(posedge clk); #1;
    cpu_addr = 32'h300; cpu_read = 1'b1; bus_ready = in_wait; bus_rvalid = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (bus_valid) seen = 1'b1;
      if (in_wait ? (seen && !bus_valid) : bus_valid) hit = 1'b1;
    end
    chk({nm, "_reached"}, 32'(hit), 32'd1);
    chk({nm, "_stall_before"}, 32'(cpu_stall), 32'd1);
    rst = 1'b0;
    #1;
    chk({nm, "_valid_in_rst"}, 32'(bus_valid), 32'd0);
    chk({nm, "_stall_in_rst"}, 32'(cpu_stall), 32'd0);
    chk({nm, "_rdata_in_rst"}, cpu_rdata, 32'h0);
    cpu_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk({nm, "_idle_after"}, 32'({cpu_stall, bus_valid, cpu_err}), 32'd0);
  endtask

  initial begin
    int v_n = 0;
    int s_n = 0;
    bit done = 1'b0;
    logic [31:0] t_addr = 32'h0;
    logic [31:0] t_rdata = 32'h0;
    logic        t_err = 1'b0;

    // Reset: a held load request must not raise stall while in reset.
    cpu_read = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    chk("rst_cpu_err", 32'(cpu_err), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_to_stall", 32'(to_cpu_stall), 32'd0);
    cpu_read = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    //             addr       rd    wr    wd            brd          hold give e_addr     e_we  e_wd          e_rdata       err   stall valid
    tbl.push_back('{32'h100, 1'b0, 4'hF, 32'hA5A5_1234, 32'h0,        0, 1'b0, 32'h100, 4'hF, 32'hA5A5_1234, 32'h0,        1'b0, 2,   1});
    tbl.push_back('{32'h103, 1'b0, 4'h1, 32'h0000_0077, 32'h0,        0, 1'b0, 32'h100, 4'h8, 32'h7700_0000, 32'h0,        1'b0, 2,   1});
    tbl.push_back('{32'h202, 1'b1, 4'h0, 32'h0,         32'hBEEF_0000, 0, 1'b1, 32'h200, 4'h0, 32'h0,         32'h0000_BEEF, 1'b0, 3,   1});
    tbl.push_back('{32'h402, 1'b0, 4'h3, 32'h0000_CAFE, 32'h0,        0, 1'b0, 32'h400, 4'hC, 32'hCAFE_0000, 32'h0000_BEEF, 1'b0, 2,   1});
    tbl.push_back('{32'h500, 1'b1, 4'h0, 32'h0,         32'h1234_5678, 0, 1'b1, 32'h500, 4'h0, 32'h0,         32'h1234_5678, 1'b0, 3,   1});
    tbl.push_back('{32'h601, 1'b1, 4'h0, 32'h0,         32'hAABB_CCDD, 0, 1'b1, 32'h600, 4'h0, 32'h0,         32'h00AA_BBCC, 1'b0, 3,   1});
    tbl.push_back('{32'h700, 1'b1, 4'hF, 32'h1122_3344, 32'h0,        0, 1'b1, 32'h700, 4'hF, 32'h1122_3344, 32'h00AA_BBCC, 1'b0, 2,   1});
    tbl.push_back('{32'h800, 1'b0, 4'hF, 32'hCAFE_F00D, 32'h0,        5, 1'b0, 32'h800, 4'hF, 32'hCAFE_F00D, 32'h00AA_BBCC, 1'b0, 7,   6});
    tbl.push_back('{32'h904, 1'b1, 4'h0, 32'h0,         32'h0BAD_F00D, 2, 1'b1, 32'h904, 4'h0, 32'h0,         32'h0BAD_F00D, 1'b0, 5,   3});
    // Load never answered: IDLE + 255 cycles in REQ/WAIT_R, then error with zeroed data.
    tbl.push_back('{32'hA00, 1'b1, 4'h0, 32'h0,         32'h0,        0, 1'b0, 32'hA00, 4'h0, 32'h0,         32'h0,         1'b1, 256, 1});

    for (int i = 0; i < tbl.size(); i++) begin
      run_txn(tbl[i], $sformatf("v%0d", i));
    end

    @(negedge clk);
    chk("timeout_err_one_cycle", 32'(cpu_err), 32'd0);

    // A bus_rvalid while idle must not touch cpu_rdata.
    bus_rdata = 32'hDEAD_BEEF;
    bus_rvalid = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rvalid_rdata", cpu_rdata, 32'h0);
    chk("late_rvalid_stall", 32'(cpu_stall), 32'd0);

    // TIMEOUT_CYC=4 instance, ready never asserted.
    @(posedge clk); #1;
    cpu_addr = 32'h900; cpu_wdata = 32'h0; to_read = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (to_bus_valid) begin
        v_n++;
        t_addr = to_bus_addr;
      end
      if (to_cpu_stall) s_n++;
      else begin
        done = 1'b1;
        t_err = to_cpu_err;
        t_rdata = to_cpu_rdata;
      end
    end
    to_read = 1'b0;
    chk("to_done", 32'(done), 32'd1);
    chk("to_valid_cycles", v_n, 32'd4);
    chk("to_stall_cycles", s_n, 32'd5);
    chk("to_bus_addr", t_addr, 32'h900);
    chk("to_bus_we", 32'(to_bus_we), 32'd0);
    chk("to_bus_wdata", to_bus_wdata, 32'h0);
    chk("to_err", 32'(t_err), 32'd1);
    chk("to_rdata", t_rdata, 32'h0);
    @(negedge clk);
    chk("to_err_one_cycle", 32'(to_cpu_err), 32'd0);

    reset_mid(1'b1, "rst_wait_r");
    reset_mid(1'b0, "rst_req");
    run_txn('{32'h300, 1'b1, 4'h0, 32'h0, 32'h0000_0001, 0, 1'b1,
              32'h300, 4'h0, 32'h0, 32'h0000_0001, 1'b0, 3, 1}, "after_rst_load");

`ifdef MISALIGN_CHECK_EN
    run_txn('{32'h101, 1'b0, 4'hF, 32'h4433_2211, 32'h0, 0, 1'b0,
              32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 0}, "misalign_word_store");
    run_txn('{32'h103, 1'b0, 4'h3, 32'h0000_BEEF, 32'h0, 0, 1'b0,
              32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 0}, "misalign_half_store");
    run_txn('{32'h202, 1'b1, 4'h0, 32'h0, 32'h1234_5678, 0, 1'b1,
              32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 0}, "misalign_load");
`else
    run_txn('{32'h101, 1'b0, 4'hF, 32'h4433_2211, 32'h0, 0, 1'b0,
              32'h100, 4'hE, 32'h3322_1100, 32'h0000_0001, 1'b0, 2, 1}, "trunc_word_store");
    run_txn('{32'h103, 1'b0, 4'h3, 32'h0000_BEEF, 32'h0, 0, 1'b0,
              32'h100, 4'h8, 32'hEF00_0000, 32'h0000_0001, 1'b0, 2, 1}, "trunc_half_store");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
